// File: rtl/fsk_pkg.sv
// Shared types and constants for the 2-FSK word feeder and its FIFO.
package fsk_pkg;

    localparam int FSK_WORD_W = 32;
    localparam logic [FSK_WORD_W-1:0] FSK_IDLE_WORD_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        ARM  = 1'b0,
        TAIL = 1'b1
    } feeder_state_t;

endpackage

// File: rtl/fsk_word_fifo.sv
// Synchronous word FIFO with a combinational head read and a count-difference level.
module fsk_word_fifo
    import fsk_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  logic [FSK_WORD_W-1:0]   wdata,
    output logic [FSK_WORD_W-1:0]   rdata,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [FSK_WORD_W-1:0] mem [DEPTH];
    logic [LW-1:0]         wr_cnt;
    logic [LW-1:0]         rd_cnt;
    logic                  push_ok;
    logic                  pop_ok;

    // Counters carry one extra bit so full and empty stay distinguishable.
    assign level   = wr_cnt - rd_cnt;
    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_cnt[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_cnt <= '0;
            rd_cnt <= '0;
        end else begin
            if (push_ok) wr_cnt <= wr_cnt + 1'b1;
            if (pop_ok)  rd_cnt <= rd_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_cnt[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/fsk_word_feeder.sv
// Holds one payload word on the modulator input per packet, advancing only on the
// falling edge of pkt_done. Optional underrun counter under FSK_FEEDER_UNDERRUN_CNT_EN.
//
// state | meaning
// ARM   | waiting for pkt_done (sampled) to go high
// TAIL  | bit 31 on air; the sampled fall is the packet boundary
module fsk_word_feeder
    import fsk_pkg::*;
#(
    parameter int                     DEPTH     = 8,
    parameter logic [FSK_WORD_W-1:0]  IDLE_WORD = FSK_IDLE_WORD_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [FSK_WORD_W-1:0]   s_tdata,
    input  logic                    s_tvalid,
    output logic                    s_tready,
    input  logic                    pkt_done,
    output logic [FSK_WORD_W-1:0]   mod_tdata,
    output logic                    word_is_idle,
    output logic [$clog2(DEPTH):0]  fifo_level,
    output logic                    underrun
`ifdef FSK_FEEDER_UNDERRUN_CNT_EN
    ,
    output logic [15:0]             underrun_cnt
`endif
);

    feeder_state_t          state;
    logic                   pkt_q;
    logic                   push;
    logic                   pop;
    logic                   boundary;
    logic                   full;
    logic                   empty;
    logic [FSK_WORD_W-1:0]  head;

    // empty comes from the registered level, so a push in the boundary cycle
    // cannot be forwarded and the boundary takes the underrun path.
    assign s_tready = rst && !full;
    assign push     = s_tvalid && s_tready;
    assign boundary = (state == TAIL) && !pkt_q;
    assign pop      = boundary && !empty;

    fsk_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (s_tdata),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= ARM;
            pkt_q        <= 1'b0;
            mod_tdata    <= IDLE_WORD;
            word_is_idle <= 1'b1;
            underrun     <= 1'b0;
`ifdef FSK_FEEDER_UNDERRUN_CNT_EN
            underrun_cnt <= 16'h0000;
`endif
        end else begin
            pkt_q    <= pkt_done;
            underrun <= 1'b0;
            case (state)
                ARM: begin
                    if (pkt_q) state <= TAIL;
                end
                TAIL: begin
                    if (!pkt_q) begin
                        state <= ARM;
                        if (!empty) begin
                            mod_tdata    <= head;
                            word_is_idle <= 1'b0;
                        end else begin
                            mod_tdata    <= IDLE_WORD;
                            word_is_idle <= 1'b1;
                            underrun     <= 1'b1;
`ifdef FSK_FEEDER_UNDERRUN_CNT_EN
                            if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
`endif
                        end
                    end
                end
                default: state <= ARM;
            endcase
        end
    end

endmodule

// File: tb/tb_fsk_word_feeder.sv
// Directed bench for fsk_word_feeder: reset, idle underrun, fill, stretched done,
// boundary collision and mid-packet reset.
module tb_fsk_word_feeder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic        pkt_done;
    logic [31:0] mod_tdata;
    logic        word_is_idle;
    logic [3:0]  fifo_level;
    logic        underrun;
`ifdef FSK_FEEDER_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] words [9];

    always #5 clk = ~clk;

    fsk_word_feeder #(
        .DEPTH     (8),
        .IDLE_WORD (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_tdata      (s_tdata),
        .s_tvalid     (s_tvalid),
        .s_tready     (s_tready),
        .pkt_done     (pkt_done),
        .mod_tdata    (mod_tdata),
        .word_is_idle (word_is_idle),
        .fifo_level   (fifo_level),
        .underrun     (underrun)
`ifdef FSK_FEEDER_UNDERRUN_CNT_EN
        ,
        .underrun_cnt (underrun_cnt)
`endif
    );

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive pkt_done high for hi cycles, then drop it; returns two edges after the fall.
    task automatic packet(input int hi);
        pkt_done = 1'b1;
        tick(hi);
        pkt_done = 1'b0;
        tick(2);
    endtask

    initial begin
        for (int i = 0; i < 9; i++) words[i] = 32'h1000_0001 + 32'(i) * 32'h0101_0000;
        rst      = 1'b0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        pkt_done = 1'b0;

        // reset
        tick(1);
        s_tvalid = 1'b1;
        check_val("rst_mod", mod_tdata, 32'h0);
        check_val("rst_idle", 32'(word_is_idle), 32'd1);
        check_val("rst_level", 32'(fifo_level), 32'd0);
        check_val("rst_underrun", 32'(underrun), 32'd0);
        check_val("rst_tready", 32'(s_tready), 32'd0);
        tick(3);
        check_val("rst_no_push", 32'(fifo_level), 32'd0);
        s_tvalid = 1'b0;
        rst = 1'b1;
        tick(1);
        check_val("tready_after_rst", 32'(s_tready), 32'd1);

        // idle packet: underrun two edges after the fall
        tick(5);
        pkt_done = 1'b1;
        tick(10);
        check_val("idle_no_early_underrun", 32'(underrun), 32'd0);
        pkt_done = 1'b0;
        tick(1);
        check_val("idle_underrun_n1", 32'(underrun), 32'd0);
        tick(1);
        check_val("idle_underrun_n2", 32'(underrun), 32'd1);
        check_val("idle_mod", mod_tdata, 32'h0);
        check_val("idle_flag", 32'(word_is_idle), 32'd1);
        tick(1);
        check_val("idle_underrun_n3", 32'(underrun), 32'd0);

        // single word
        s_tdata  = 32'hA5A5_0F0F;
        s_tvalid = 1'b1;
        tick(1);
        s_tvalid = 1'b0;
        check_val("single_level1", 32'(fifo_level), 32'd1);
        pkt_done = 1'b1;
        tick(3);
        check_val("single_no_midload", mod_tdata, 32'h0);
        pkt_done = 1'b0;
        tick(1);
        check_val("single_n1_mod", mod_tdata, 32'h0);
        tick(1);
        check_val("single_mod", mod_tdata, 32'hA5A5_0F0F);
        check_val("single_idle", 32'(word_is_idle), 32'd0);
        check_val("single_underrun", 32'(underrun), 32'd0);
        check_val("single_level0", 32'(fifo_level), 32'd0);

        // fill past depth
        for (int i = 0; i < 8; i++) begin
            s_tdata  = words[i];
            s_tvalid = 1'b1;
            tick(1);
        end
        check_val("fill_tready_full", 32'(s_tready), 32'd0);
        check_val("fill_level8", 32'(fifo_level), 32'd8);
        s_tdata = words[8];
        tick(2);
        check_val("fill_hold_level", 32'(fifo_level), 32'd8);
        packet(3);
        check_val("fill_word1", mod_tdata, words[0]);
        check_val("fill_level_after_pop", 32'(fifo_level), 32'd7);
        check_val("fill_tready_freed", 32'(s_tready), 32'd1);
        tick(1);
        s_tvalid = 1'b0;
        check_val("fill_word9_in", 32'(fifo_level), 32'd8);
        packet(3);
        check_val("fill_word2", mod_tdata, words[1]);
        packet(3);
        check_val("fill_word3", mod_tdata, words[2]);
        check_val("fill_level6", 32'(fifo_level), 32'd6);

        // stretched pkt_done: one pop only at the fall
        pkt_done = 1'b1;
        tick(1000);
        check_val("stretch_level_high", 32'(fifo_level), 32'd6);
        check_val("stretch_mod_high", mod_tdata, words[2]);
        pkt_done = 1'b0;
        tick(2);
        check_val("stretch_word4", mod_tdata, words[3]);
        check_val("stretch_level5", 32'(fifo_level), 32'd5);

        // drain remaining words in order
        for (int i = 4; i < 9; i++) begin
            packet(4);
            check_val("drain_word", mod_tdata, words[i]);
        end
        check_val("drain_level0", 32'(fifo_level), 32'd0);
        check_val("drain_idle", 32'(word_is_idle), 32'd0);

        // push into empty FIFO during the boundary cycle
        pkt_done = 1'b1;
        tick(3);
        pkt_done = 1'b0;
        tick(1);
        s_tdata  = 32'hC0FF_EE11;
        s_tvalid = 1'b1;
        tick(1);
        s_tvalid = 1'b0;
        check_val("coll_mod_idle", mod_tdata, 32'h0);
        check_val("coll_idle", 32'(word_is_idle), 32'd1);
        check_val("coll_underrun", 32'(underrun), 32'd1);
        check_val("coll_level1", 32'(fifo_level), 32'd1);
        packet(3);
        check_val("coll_next_word", mod_tdata, 32'hC0FF_EE11);
        check_val("coll_next_idle", 32'(word_is_idle), 32'd0);

        // reset mid-packet with 3 words queued
        for (int i = 0; i < 3; i++) begin
            s_tdata  = words[i];
            s_tvalid = 1'b1;
            tick(1);
        end
        s_tvalid = 1'b0;
        pkt_done = 1'b1;
        tick(3);
        check_val("midrst_level3", 32'(fifo_level), 32'd3);
`ifdef FSK_FEEDER_UNDERRUN_CNT_EN
        check_val("midrst_cnt_before", 32'(underrun_cnt), 32'd2);
`endif
        rst = 1'b0;
        tick(1);
        check_val("midrst_level0", 32'(fifo_level), 32'd0);
        check_val("midrst_mod", mod_tdata, 32'h0);
        check_val("midrst_idle", 32'(word_is_idle), 32'd1);
        check_val("midrst_tready", 32'(s_tready), 32'd0);
`ifdef FSK_FEEDER_UNDERRUN_CNT_EN
        check_val("midrst_cnt", 32'(underrun_cnt), 32'd0);
`endif
        pkt_done = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(2);
        packet(3);
        check_val("post_rst_underrun", 32'(underrun), 32'd1);
        check_val("post_rst_mod", mod_tdata, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
